sr_lsu: RTL and testbench

Load/store unit for the schoolRISCV core, placed between `sr_cpu` and the data memory bus. It accepts one memory operation per instruction, checks alignment, and steers byte lanes for stores. For loads it extracts the byte, halfword or word and sign- or zero-extends it. It drives a req/ack handshake toward memory and stalls the CPU until the operation completes or faults.

---
 rtl/sr_lsu_pkg.sv | 35 +++
 rtl/sr_lsu_align.sv | 66 ++++++
 rtl/sr_lsu.sv | 167 ++++++++++++++++
 tb/tb_sr_lsu.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_lsu_pkg.sv
// Shared definitions for the schoolRISCV load/store unit: funct3 codes,
// FSM state encoding and the access legality check.
package sr_lsu_pkg;

    localparam logic [2:0] RVF3_LB  = 3'b000;
    localparam logic [2:0] RVF3_LH  = 3'b001;
    localparam logic [2:0] RVF3_LW  = 3'b010;
    localparam logic [2:0] RVF3_LBU = 3'b100;
    localparam logic [2:0] RVF3_LHU = 3'b101;
    localparam logic [2:0] RVF3_SB  = 3'b000;
    localparam logic [2:0] RVF3_SH  = 3'b001;
    localparam logic [2:0] RVF3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    // Unsigned variants only exist for loads; halfword/word need natural alignment.
    function automatic logic lsu_fault(input logic we, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic f;
        case (f3)
            RVF3_LB:  f = 1'b0;
            RVF3_LH:  f = off[0];
            RVF3_LW:  f = (off != 2'b00);
            RVF3_LBU: f = we;
            RVF3_LHU: f = we | off[0];
            default:  f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sr_lsu_align.sv
// Byte-lane steering: store replication/byte enables from the request,
// and load shift/extension of the returned bus word.
module sr_lsu_align
    import sr_lsu_pkg::*;
(
    input  logic [2:0]  st_f3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    input  logic [2:0]  ld_f3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store path: replicate the datum across lanes, enable only the addressed bytes.
    always_comb begin
        st_be        = 4'b0000;
        st_wdata_rep = st_wdata;
        case (st_f3)
            RVF3_SB: begin
                st_be        = 4'b0001 << st_off;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            RVF3_SH: begin
                st_be        = 4'b0011 << st_off;
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            RVF3_SW: begin
                st_be        = 4'b1111;
                st_wdata_rep = st_wdata;
            end
            default: begin
                st_be        = 4'b0000;
                st_wdata_rep = st_wdata;
            end
        endcase
    end

    // Load path: pick the addressed byte/halfword, then extend by funct3.
    always_comb begin
        ld_byte = ld_rdata[7:0];
        ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data = 32'h0000_0000;
        case (ld_off)
            2'b00:   ld_byte = ld_rdata[7:0];
            2'b01:   ld_byte = ld_rdata[15:8];
            2'b10:   ld_byte = ld_rdata[23:16];
            2'b11:   ld_byte = ld_rdata[31:24];
            default: ld_byte = ld_rdata[7:0];
        endcase
        case (ld_f3)
            RVF3_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            RVF3_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            RVF3_LW:  ld_data = ld_rdata;
            RVF3_LBU: ld_data = {24'h00_0000, ld_byte};
            RVF3_LHU: ld_data = {16'h0000, ld_half};
            default:  ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/sr_lsu.sv
// Load/store unit between sr_cpu and the data bus: decode/alignment check,
// req/ack handshake with timeout, and a one-cycle completion pulse.
module sr_lsu
    import sr_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsuReq,
    input  logic        lsuWe,
    input  logic [2:0]  lsuF3,
    input  logic [31:0] lsuAddr,
    input  logic [31:0] lsuWData,
    output logic        lsuStall,
    output logic [31:0] lsuRData,
    output logic        lsuDone,
    output logic        lsuErr,
    output logic        memReq,
    output logic        memWe,
    output logic [3:0]  memBe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic        memAck,
    input  logic [31:0] memRData
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    logic [3:0]  st_be_s;
    logic [31:0] st_wdata_s;
    logic [31:0] ld_data_s;

    sr_lsu_align u_align (
        .st_f3        (lsuF3),
        .st_off       (lsuAddr[1:0]),
        .st_wdata     (lsuWData),
        .st_be        (st_be_s),
        .st_wdata_rep (st_wdata_s),
        .ld_f3        (f3_q),
        .ld_off       (off_q),
        .ld_rdata     (memRData),
        .ld_data      (ld_data_s)
    );

    // Next-state and registered-output logic; bus signals only change on BUS entry/exit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        f3_d        = f3_q;
        off_d       = off_q;
        case (state_q)
            LSU_IDLE: begin
                if (lsuReq) begin
                    if (lsu_fault(lsuWe, lsuF3, lsuAddr[1:0])) begin
                        state_d = LSU_RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0000_0000;
                    end else begin
                        state_d     = LSU_BUS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = lsuWe;
                        mem_be_d    = lsuWe ? st_be_s : 4'b1111;
                        mem_addr_d  = {lsuAddr[31:2], 2'b00};
                        mem_wdata_d = st_wdata_s;
                        f3_d        = lsuF3;
                        off_d       = lsuAddr[1:0];
                    end
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_BUS: begin
                if (memAck) begin
                    state_d   = LSU_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    rdata_d   = mem_we_q ? 32'h0000_0000 : ld_data_s;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = LSU_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d   = LSU_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LSU_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
        end
    end

    assign memReq   = mem_req_q;
    assign memWe    = mem_we_q;
    assign memBe    = mem_be_q;
    assign memAddr  = mem_addr_q;
    assign memWData = mem_wdata_q;
    assign lsuDone  = done_q;
    assign lsuErr   = err_q;
    assign lsuRData = rdata_q;
    assign lsuStall = lsuReq & ~done_q;

endmodule

// File: tb/tb_sr_lsu.sv
// Self-checking bench for sr_lsu: directed vector table, hand-written reset
// sequence, and randomized operations against a byte-level reference model.
module tb_sr_lsu;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsuReq, lsuWe;
    logic [2:0]  lsuF3;
    logic [31:0] lsuAddr, lsuWData;
    logic        lsuStall, lsuDone, lsuErr;
    logic [31:0] lsuRData;
    logic        memReq, memWe, memAck;
    logic [3:0]  memBe;
    logic [31:0] memAddr, memWData, memRData;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sr_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsuReq(lsuReq), .lsuWe(lsuWe), .lsuF3(lsuF3), .lsuAddr(lsuAddr),
        .lsuWData(lsuWData), .lsuStall(lsuStall), .lsuRData(lsuRData),
        .lsuDone(lsuDone), .lsuErr(lsuErr),
        .memReq(memReq), .memWe(memWe), .memBe(memBe), .memAddr(memAddr),
        .memWData(memWData), .memAck(memAck), .memRData(memRData)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack;     // cycle memAck is driven high (-1: never)
        logic [31:0] rd;
        int          done;    // expected lsuDone cycle
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        int          reqs;    // expected number of cycles with memReq high
    } vec_t;

    typedef struct {
        int          done;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] stall;
        int          reqs;
        logic        we;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
    } res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input int ack, input logic [31:0] rd,
                                 input int done, input logic err, input logic [31:0] rdata,
                                 input logic [3:0] be, input logic [31:0] maddr,
                                 input logic [31:0] mwdata, input int reqs);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd; v.ack = ack; v.rd = rd;
        v.done = done; v.err = err; v.rdata = rdata; v.be = be; v.maddr = maddr;
        v.mwdata = mwdata; v.reqs = reqs;
        return v;
    endfunction

    // Reference model: computes the outcome from access size, offset and funct3 rules.
    function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wd, input int ack, input logic [31:0] rd);
        vec_t v;
        int off, size, f;
        bit bad;
        logic [31:0] val, mask;
        f    = int'(f3);
        off  = int'(addr % 32'd4);
        size = (f % 4 == 0) ? 1 : ((f % 4 == 1) ? 2 : 4);
        bad  = (f == 3) || (f == 6) || (f == 7) || (we && (f == 4 || f == 5)) || (off % size != 0);
        v = mkv(we, f3, addr, wd, ack, rd, 0, 1'b0, 32'h0, 4'hF, addr & 32'hFFFF_FFFC, wd, 0);
        if (we) begin
            v.be = 4'h0;
            for (int i = 0; i < 4; i++) begin
                v.be[i] = (i >= off) && (i < off + size);
                v.mwdata[8*i +: 8] = wd[8*(i % size) +: 8];
            end
        end
        val = rd >> (8 * off);
        if (size < 4) begin
            mask = (32'd1 << (8 * size)) - 32'd1;
            val  = val & mask;
            if (f < 4 && val[8*size-1]) val = val | ~mask;
        end
        if (bad) begin
            v.done = 1; v.err = 1'b1; v.reqs = 0; v.rdata = 32'h0;
        end else if (ack >= 1 && ack <= TIMEOUT) begin
            v.done = ack + 1; v.err = 1'b0; v.reqs = ack; v.rdata = val;
        end else begin
            v.done = TIMEOUT + 1; v.err = 1'b1; v.reqs = TIMEOUT; v.rdata = 32'h0;
        end
        return v;
    endfunction

    // Entered just after a rising edge; that cycle is cycle 0 of the access.
    task automatic do_op(input vec_t v, output res_t r);
        bit seen = 0;
        r.done = -1; r.err = 1'b0; r.rdata = 32'h0; r.stall = 32'h0; r.reqs = 0;
        r.we = 1'b0; r.be = 4'h0; r.maddr = 32'h0; r.mwdata = 32'h0;
        lsuReq = 1'b1; lsuWe = v.we; lsuF3 = v.f3; lsuAddr = v.addr; lsuWData = v.wdata;
        memRData = v.rd;
        for (int c = 0; c < TIMEOUT + 6; c++) begin
            memAck = (c == v.ack);
            @(negedge clk);
            r.stall[c] = lsuStall;
            if (memReq) begin
                r.reqs++;
                if (!seen) begin
                    seen = 1; r.we = memWe; r.be = memBe; r.maddr = memAddr; r.mwdata = memWData;
                end
            end
            if (lsuDone) begin
                r.done = c; r.err = lsuErr; r.rdata = lsuRData;
            end
            @(posedge clk); #1;
            if (r.done >= 0) break;
        end
        lsuReq = 1'b0; memAck = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        res_t r;
        do_op(v, r);
        check({tag, " done_cycle"}, 32'(r.done), 32'(v.done));
        check({tag, " err"}, 32'(r.err), 32'(v.err));
        check({tag, " stall"}, r.stall, 32'((64'd1 << v.done) - 64'd1));
        check({tag, " req_cycles"}, 32'(r.reqs), 32'(v.reqs));
        if (v.reqs > 0) begin
            check({tag, " memWe"}, 32'(r.we), 32'(v.we));
            check({tag, " memBe"}, 32'(r.be), 32'(v.be));
            check({tag, " memAddr"}, r.maddr, v.maddr);
            if (v.we) check({tag, " memWData"}, r.mwdata, v.mwdata);
        end
        if ((!v.we && !v.err) || (v.err && v.reqs > 0))
            check({tag, " lsuRData"}, r.rdata, v.rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   dones;

        rst_n = 1'b0; lsuReq = 1'b0; lsuWe = 1'b0; lsuF3 = 3'b000;
        lsuAddr = 32'h0; lsuWData = 32'h0; memAck = 1'b0; memRData = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst memReq", 32'(memReq), 32'h0);
        check("rst memWe", 32'(memWe), 32'h0);
        check("rst memBe", 32'(memBe), 32'h0);
        check("rst memAddr", memAddr, 32'h0);
        check("rst memWData", memWData, 32'h0);
        check("rst lsuDone", 32'(lsuDone), 32'h0);
        check("rst lsuErr", 32'(lsuErr), 32'h0);
        check("rst lsuRData", lsuRData, 32'h0);
        @(posedge clk); #1;

        //          we   f3      addr          wdata         ack rd            done err rdata         be     maddr         mwdata      reqs
        tbl.push_back(mkv(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h0, 2, 1'b0, 32'h0, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 1));
        tbl.push_back(mkv(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1, 32'h0, 2, 1'b0, 32'h0, 4'h8, 32'h0000_0100, 32'hA5A5_A5A5, 1));
        tbl.push_back(mkv(1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 1, 32'h0, 2, 1'b0, 32'h0, 4'hC, 32'h0000_0100, 32'hBEEF_BEEF, 1));
        tbl.push_back(mkv(1'b0, 3'b000, 32'h0000_0102, 32'h0, 1, 32'h1280_3456, 2, 1'b0, 32'hFFFF_FF80, 4'hF, 32'h0000_0100, 32'h0, 1));
        tbl.push_back(mkv(1'b0, 3'b100, 32'h0000_0102, 32'h0, 1, 32'h1280_3456, 2, 1'b0, 32'h0000_0080, 4'hF, 32'h0000_0100, 32'h0, 1));
        tbl.push_back(mkv(1'b0, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h1280_3456, 2, 1'b0, 32'h0000_1280, 4'hF, 32'h0000_0100, 32'h0, 1));
        tbl.push_back(mkv(1'b0, 3'b010, 32'h0000_0100, 32'h0, 1, 32'h1280_3456, 2, 1'b0, 32'h1280_3456, 4'hF, 32'h0000_0100, 32'h0, 1));
        tbl.push_back(mkv(1'b0, 3'b101, 32'h0000_0202, 32'h0, 2, 32'hF00D_8765, 3, 1'b0, 32'h0000_F00D, 4'hF, 32'h0000_0200, 32'h0, 2));
        tbl.push_back(mkv(1'b0, 3'b001, 32'h0000_0202, 32'h0, 2, 32'hF00D_8765, 3, 1'b0, 32'hFFFF_F00D, 4'hF, 32'h0000_0200, 32'h0, 2));
        tbl.push_back(mkv(1'b0, 3'b000, 32'h0000_0101, 32'h0, 1, 32'h1280_3456, 2, 1'b0, 32'h0000_0034, 4'hF, 32'h0000_0100, 32'h0, 1));
        tbl.push_back(mkv(1'b0, 3'b001, 32'h0000_0101, 32'h0, 1, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 0));
        tbl.push_back(mkv(1'b1, 3'b100, 32'h0000_0100, 32'h0, 1, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 0));
        tbl.push_back(mkv(1'b0, 3'b010, 32'h0000_0102, 32'h0, 1, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 0));
        tbl.push_back(mkv(1'b0, 3'b011, 32'h0000_0100, 32'h0, 1, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 0));
        tbl.push_back(mkv(1'b0, 3'b110, 32'h0000_0100, 32'h0, 1, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 0));
        tbl.push_back(mkv(1'b1, 3'b111, 32'h0000_0100, 32'h0, 1, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 0));
        tbl.push_back(mkv(1'b0, 3'b000, 32'h0000_0100, 32'h0, 4, 32'h0000_00FF, 5, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0000_0100, 32'h0, 4));
        tbl.push_back(mkv(1'b0, 3'b010, 32'h0000_0100, 32'h0, -1, 32'h0, 17, 1'b1, 32'h0, 4'hF, 32'h0000_0100, 32'h0, 16));
        tbl.push_back(mkv(1'b0, 3'b010, 32'h0000_0104, 32'h0, 16, 32'hCAFE_F00D, 17, 1'b0, 32'hCAFE_F00D, 4'hF, 32'h0000_0104, 32'h0, 16));
        tbl.push_back(mkv(1'b0, 3'b010, 32'h0000_0104, 32'h0, 0, 32'h1111_2222, 17, 1'b1, 32'h0, 4'hF, 32'h0000_0104, 32'h0, 16));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted in cycle 2 of a bus access aborts it with no completion.
        lsuReq = 1'b1; lsuWe = 1'b0; lsuF3 = 3'b010; lsuAddr = 32'h0000_0200; memAck = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_abort memReq_c1", 32'(memReq), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; lsuReq = 1'b0;
        @(negedge clk);
        check("rst_abort memReq_c3", 32'(memReq), 32'h0);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (lsuDone || memReq) dones++;
        end
        check("rst_abort no_done", 32'(dones), 32'h0);
        @(posedge clk); #1;
        run_vec(model(1'b0, 3'b010, 32'h0000_0300, 32'h0, 1, 32'h5A5A_0F0F), "post_rst");

        for (int n = 0; n < 80; n++) begin
            int sel, ack;
            sel = int'($urandom_range(0, 9));
            ack = (sel == 0) ? -1 : (sel == 1) ? 0 : (sel == 2) ? TIMEOUT : int'($urandom_range(1, 5));
            v = model(1'($urandom), 3'($urandom), 32'($urandom), 32'($urandom), ack, 32'($urandom));
            run_vec(v, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
